// File: rtl/constants_pkg.sv
// Shared constants for the ALU result path: statistics width, default
// result FIFO depth, and the ALU operation selection encoding.
package constants_pkg;

    localparam int STAT_WIDTH     = 16;
    localparam int RES_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_sel_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one when inc_i is high and holds at
// the all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: step only while below the saturation value.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/alu_result_fifo.sv
// Registered FIFO buffering ALU results with their zero/negative flags.
// Handshakes on both sides derive only from the occupancy register, so
// there is no combinational path from any input to any output.
// Optional feature: define ALU_RESULT_FIFO_STATS_EN to count accepted
// results with the zero and negative flags set (saturating counters);
// otherwise zero_cnt_o/neg_cnt_o are tied to 0.
module alu_result_fifo
    import constants_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = RES_FIFO_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DWIDTH-1:0]       res_i,
    input  logic                    zero_i,
    input  logic                    neg_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DWIDTH-1:0]       res_o,
    output logic                    zero_o,
    output logic                    neg_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [STAT_WIDTH-1:0]   zero_cnt_o,
    output logic [STAT_WIDTH-1:0]   neg_cnt_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DWIDTH + 2;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // A flush wins over any same-cycle push or pop.
    assign out_valid_o = (count_q != '0);
    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {res_i, zero_i, neg_i};
        end
    end

    // Head is masked to zero when empty so stale entries never leak out.
    assign head    = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign res_o   = head[ENTRY_W-1:2];
    assign zero_o  = head[1];
    assign neg_o   = head[0];
    assign count_o = count_q;

`ifdef ALU_RESULT_FIFO_STATS_EN
    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_zero_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (push & zero_i),
        .cnt_o  (zero_cnt_o)
    );

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_neg_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (push & neg_i),
        .cnt_o  (neg_cnt_o)
    );
`else
    assign zero_cnt_o = '0;
    assign neg_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Testbench for alu_result_fifo: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_alu_result_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP) + 1;
`ifdef ALU_RESULT_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] res_i;
    logic          zero_i;
    logic          neg_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] res_o;
    logic          zero_o;
    logic          neg_o;
    logic [CW-1:0] count_o;
    logic [15:0]   zero_cnt_o;
    logic [15:0]   neg_cnt_o;

    int total = 0;
    int bad   = 0;

    alu_result_fifo #(
        .DWIDTH (DW),
        .DEPTH  (DP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .res_i       (res_i),
        .zero_i      (zero_i),
        .neg_i       (neg_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .res_o       (res_o),
        .zero_o      (zero_o),
        .neg_o       (neg_o),
        .count_o     (count_o),
        .zero_cnt_o  (zero_cnt_o),
        .neg_cnt_o   (neg_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic [DW-1:0] res;
        logic          z;
        logic          n;
        logic [CW-1:0] e_cnt;
        logic          e_ov;
        logic          e_ir;
        logic [DW-1:0] e_res;
        logic          e_z;
        logic          e_n;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [DW-1:0] res, input logic z, input logic n,
                                input logic [CW-1:0] e_cnt, input logic e_ov, input logic e_ir,
                                input logic [DW-1:0] e_res, input logic e_z, input logic e_n);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.res = res; v.z = z; v.n = n;
        v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res; v.e_z = e_z; v.e_n = e_n;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock and land just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [DW-1:0] res, input logic z, input logic n);
        in_valid_i  = iv;
        out_ready_i = ordy;
        flush_i     = fl;
        res_i       = res;
        zero_i      = z;
        neg_i       = n;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
    endtask

    // Reference model state
    logic [DW+1:0] mq[$];
    int            mzc;
    int            mnc;

    task automatic model_step();
        bit rdy;
        bit vld;
        rdy = (mq.size() != DP);
        vld = (mq.size() != 0);
        if (flush_i) begin
            mq.delete();
        end else begin
            if (vld && out_ready_i) void'(mq.pop_front());
            if (in_valid_i && rdy) begin
                mq.push_back({res_i, zero_i, neg_i});
                if (STATS && zero_i && mzc < 65535) mzc++;
                if (STATS && neg_i && mnc < 65535) mnc++;
            end
        end
    endtask

    task automatic model_check();
        logic [DW+1:0] h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("rnd_count", 32'(count_o), 32'(mq.size()));
        chk("rnd_out_valid", 32'(out_valid_o), 32'(mq.size() != 0));
        chk("rnd_in_ready", 32'(in_ready_o), 32'(mq.size() != DP));
        chk("rnd_head", 32'({res_o, zero_o, neg_o}), 32'(h));
        chk("rnd_zero_cnt", 32'(zero_cnt_o), 32'(mzc));
        chk("rnd_neg_cnt", 32'(neg_cnt_o), 32'(mnc));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        #3;
        rst_ni = 1'b0;
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_res", 32'({res_o, zero_o, neg_o}), 32'd0);
        chk("rst_zero_cnt", 32'(zero_cnt_o), 32'd0);
        chk("rst_neg_cnt", 32'(neg_cnt_o), 32'd0);
        repeat (2) cyc();
        rst_ni = 1'b1;

        // Directed table: single push, fill to full, refused push, drain, full with pop
        tbl[0]  = mk(1, 0, 0, 8'h05, 0, 0, 3'd1, 1, 1, 8'h05, 0, 0);
        tbl[1]  = mk(0, 1, 0, 8'h00, 0, 0, 3'd0, 0, 1, 8'h00, 0, 0);
        tbl[2]  = mk(1, 0, 0, 8'h01, 0, 0, 3'd1, 1, 1, 8'h01, 0, 0);
        tbl[3]  = mk(1, 0, 0, 8'h02, 0, 0, 3'd2, 1, 1, 8'h01, 0, 0);
        tbl[4]  = mk(1, 0, 0, 8'h03, 0, 0, 3'd3, 1, 1, 8'h01, 0, 0);
        tbl[5]  = mk(1, 0, 0, 8'h04, 0, 0, 3'd4, 1, 0, 8'h01, 0, 0);
        tbl[6]  = mk(1, 0, 0, 8'h09, 0, 0, 3'd4, 1, 0, 8'h01, 0, 0);
        tbl[7]  = mk(0, 1, 0, 8'h00, 0, 0, 3'd3, 1, 1, 8'h02, 0, 0);
        tbl[8]  = mk(0, 1, 0, 8'h00, 0, 0, 3'd2, 1, 1, 8'h03, 0, 0);
        tbl[9]  = mk(0, 1, 0, 8'h00, 0, 0, 3'd1, 1, 1, 8'h04, 0, 0);
        tbl[10] = mk(0, 1, 0, 8'h00, 0, 0, 3'd0, 0, 1, 8'h00, 0, 0);
        tbl[11] = mk(1, 0, 0, 8'h11, 1, 0, 3'd1, 1, 1, 8'h11, 1, 0);
        tbl[12] = mk(1, 0, 0, 8'h12, 0, 1, 3'd2, 1, 1, 8'h11, 1, 0);
        tbl[13] = mk(1, 0, 0, 8'h13, 1, 1, 3'd3, 1, 1, 8'h11, 1, 0);
        tbl[14] = mk(1, 0, 0, 8'h14, 0, 0, 3'd4, 1, 0, 8'h11, 1, 0);
        tbl[15] = mk(1, 1, 0, 8'hAA, 1, 1, 3'd3, 1, 1, 8'h12, 0, 1);
        tbl[16] = mk(0, 1, 0, 8'h00, 0, 0, 3'd2, 1, 1, 8'h13, 1, 1);
        tbl[17] = mk(0, 1, 0, 8'h00, 0, 0, 3'd1, 1, 1, 8'h14, 0, 0);
        tbl[18] = mk(0, 1, 0, 8'h00, 0, 0, 3'd0, 0, 1, 8'h00, 0, 0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].res, tbl[i].z, tbl[i].n);
            cyc();
            chk($sformatf("tbl%0d_count", i), 32'(count_o), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid_o), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready_o), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_res", i), 32'(res_o), 32'(tbl[i].e_res));
            chk($sformatf("tbl%0d_zero", i), 32'(zero_o), 32'(tbl[i].e_z));
            chk($sformatf("tbl%0d_neg", i), 32'(neg_o), 32'(tbl[i].e_n));
        end

        // Steady push+pop at occupancy 2 across pointer wrap
        drive(1, 0, 0, 8'hA0, 0, 0); cyc();
        drive(1, 0, 0, 8'hA1, 0, 0); cyc();
        chk("pp_prefill_count", 32'(count_o), 32'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 8'(8'hA2 + i), 0, 0);
            cyc();
            chk($sformatf("pp%0d_count", i), 32'(count_o), 32'd2);
            chk($sformatf("pp%0d_head", i), 32'(res_o), 32'(8'(8'hA1 + i)));
        end
        drive(0, 1, 0, 8'h00, 0, 0); cyc();
        chk("pp_drain_head", 32'(res_o), 32'hAB);
        cyc();
        chk("pp_drain_empty", 32'(out_valid_o), 32'd0);

        // Flush with a same-cycle push at occupancy 3
        drive(1, 0, 0, 8'h31, 0, 0); cyc();
        drive(1, 0, 0, 8'h32, 0, 0); cyc();
        drive(1, 0, 0, 8'h33, 0, 0); cyc();
        chk("fl_prefill_count", 32'(count_o), 32'd3);
        drive(1, 0, 1, 8'h34, 1, 1); cyc();
        chk("fl_count", 32'(count_o), 32'd0);
        chk("fl_out_valid", 32'(out_valid_o), 32'd0);
        chk("fl_res", 32'({res_o, zero_o, neg_o}), 32'd0);
        drive(0, 0, 0, 8'h00, 0, 0); cyc();
        chk("fl_push_dropped", 32'(count_o), 32'd0);
        chk("fl_in_ready", 32'(in_ready_o), 32'd1);

        // Asynchronous reset in the middle of a cycle at occupancy 3
        drive(1, 0, 0, 8'h41, 1, 0); cyc();
        drive(1, 0, 0, 8'h42, 0, 1); cyc();
        drive(1, 0, 0, 8'h43, 1, 1); cyc();
        drive(0, 0, 0, 8'h00, 0, 0);
        chk("ar_prefill_count", 32'(count_o), 32'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_count", 32'(count_o), 32'd0);
        chk("ar_out_valid", 32'(out_valid_o), 32'd0);
        chk("ar_in_ready", 32'(in_ready_o), 32'd1);
        chk("ar_res", 32'({res_o, zero_o, neg_o}), 32'd0);
        chk("ar_zero_cnt", 32'(zero_cnt_o), 32'd0);
        chk("ar_neg_cnt", 32'(neg_cnt_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        drive(1, 0, 0, 8'h77, 0, 1); cyc();
        drive(0, 1, 0, 8'h00, 0, 0);
        chk("ar_first_head", 32'({res_o, zero_o, neg_o}), 32'({8'h77, 1'b0, 1'b1}));
        chk("ar_first_count", 32'(count_o), 32'd1);
        cyc();
        chk("ar_drained", 32'(count_o), 32'd0);

        // Statistics: 3 zero-flag pushes, 2 negative-flag pushes
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 8'h00, 1, 0); cyc();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 8'h80, 0, 1); cyc();
        end
        drive(0, 1, 0, 8'h00, 0, 0); cyc();
        chk("st_zero_cnt", 32'(zero_cnt_o), STATS ? 32'd3 : 32'd0);
        chk("st_neg_cnt", 32'(neg_cnt_o), STATS ? 32'd2 : 32'd0);
`ifdef ALU_RESULT_FIFO_STATS_EN
        for (int i = 0; i < 65540; i++) begin
            drive(1, 1, 0, 8'h00, 1, 0); cyc();
        end
        drive(0, 1, 0, 8'h00, 0, 0); cyc();
        chk("st_zero_sat", 32'(zero_cnt_o), 32'hFFFF);
        chk("st_neg_hold", 32'(neg_cnt_o), 32'd2);
        drive(0, 0, 1, 8'h00, 0, 0); cyc();
        drive(0, 0, 0, 8'h00, 0, 0);
        chk("st_flush_keeps", 32'(zero_cnt_o), 32'hFFFF);
`endif

        // Randomized run against the queue model
        pulse_reset();
        mq.delete();
        mzc = 0;
        mnc = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 19) == 0), 8'($urandom),
                  1'($urandom), 1'($urandom));
            model_step();
            cyc();
            model_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: width of the ALU result word.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; a power of two and at least 2.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  synchronous clear of FIFO contents.
REQ-006 SHALL have port in_valid_i  input  1  ALU result present.
REQ-007 SHALL have port in_ready_o  output  1  FIFO can accept this cycle.
REQ-008 SHALL have port res_i  input  DWIDTH  ALU result.
REQ-009 SHALL have port zero_i  input  1  ALU zero flag.
REQ-010 SHALL have port neg_i  input  1  ALU negative flag.
REQ-011 SHALL have port out_valid_o  output  1  head entry available.
REQ-012 SHALL have port out_ready_i  input  1  consumer takes head.
REQ-013 SHALL have port res_o  output  DWIDTH  head result.
REQ-014 SHALL have port zero_o  output  1  head zero flag.
REQ-015 SHALL have port neg_o  output  1  head negative flag.
REQ-016 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port zero_cnt_o  output  16  accepted results with zero flag set.
REQ-018 SHALL have port neg_cnt_o  output  16  accepted results with negative flag set.

Function
REQ-019 SHALL store a push, {res_i, zero_i, neg_i}, on each edge where in_valid_i and in_ready_o are both high.
REQ-020 SHALL pop on each edge where out_valid_o and out_ready_i are both high.
REQ-021 SHALL deliver entries in strict FIFO order, unmodified.
REQ-022 SHALL drive out_valid_o = (count_o != 0) and in_ready_o = (count_o != DEPTH), both purely from registered state with no combinational input-to-output path.
REQ-023 SHALL make a push into an empty FIFO visible on res_o/zero_o/neg_o with out_valid_o high one cycle later, with no fall-through.
REQ-024 SHALL, on simultaneous push and pop when not empty and not full, leave count_o unchanged and advance both pointers.
REQ-025 SHALL, when full, keep in_ready_o low even if out_ready_i is high that cycle.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL drive res_o/zero_o/neg_o to 0 when empty.
REQ-028 SHALL, on flush_i high, set count_o to 0 next cycle and ignore any same-cycle push or pop; flush_i SHALL NOT clear the statistics counters.
REQ-029 SHALL increment each statistics counter by 1 on an accepted push with the corresponding flag set, and saturate it at 16'hFFFF.

Reset
REQ-030 SHALL, on rst_ni low, immediately clear the pointers, set count_o=0, out_valid_o=0, in_ready_o=1, res_o/zero_o/neg_o=0, and zero_cnt_o=neg_cnt_o=0, regardless of clk_i.
REQ-031 SHALL discard all stored entries on reset mid-operation; the first push after reset release is the first entry popped.

Configuration
REQ-032 SHALL, with macro ALU_RESULT_FIFO_STATS_EN defined, implement the counters per REQ-029.
REQ-033 SHALL, with ALU_RESULT_FIFO_STATS_EN undefined, keep zero_cnt_o and neg_cnt_o as ports tied to 0 and instantiate no counter flops.

Structure
REQ-034 SHALL take package constants STAT_WIDTH=16 and RES_FIFO_DEPTH=4 from constants_pkg, alongside the existing ALU selection enumeration.
REQ-035 SHALL implement the two statistics counters as two instances of sub-module sat_counter (width STAT_WIDTH, increment-enable input, saturating).

Verification
REQ-036 SHALL cover: reset, then push res=8'h05,z=0,n=0 -> next cycle out_valid_o=1, res_o=8'h05, count_o=1.
REQ-037 SHALL cover: push 4 values 8'h01..8'h04 with out_ready_i=0 -> count_o=4, in_ready_o=0; a 5th push is not accepted; then pop 4 -> outputs 8'h01..8'h04 in order and out_valid_o=0.
REQ-038 SHALL cover: count_o=2 with simultaneous push and pop for 10 cycles -> count_o stays 2 and the output order is preserved across pointer wrap.
REQ-039 SHALL cover: count_o=3 with flush_i=1 and in_valid_i=1 in the same cycle -> next cycle count_o=0, out_valid_o=0, and the push is dropped.
REQ-040 SHALL cover: with STATS_EN, 3 pushes of res=8'h00,z=1 and 2 pushes of res=8'h80,n=1 -> zero_cnt_o=3, neg_cnt_o=2; after forcing 65540 zero pushes, zero_cnt_o=16'hFFFF.
REQ-041 SHALL cover: rst_ni asserted mid-clock with count_o=3 -> outputs reset immediately, before the next edge.
